hub75_bcm_driver: RTL and testbench

Parametrised HUB75 LED-matrix scan driver: successor to the fixed-geometry, 1-bit-per-colour screen output path behind the GPU. Reads a dual-half framebuffer (top and bottom half pixels packed per word). Drives the panel with binary-code-modulated colour depth, so each channel has 2^BITS intensity levels. Panel geometry and timing are set by parameters; output port names match the existing GPU screen interface.

---
 rtl/hub75_bcm_driver.sv | 182 ++++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan driver: shifts one bit plane of a dual-half framebuffer row per pass and
// shows each plane for BASE_ON<<plane cycles (binary-code modulation).
module hub75_bcm_driver #(
  parameter int COLS    = 64,
  parameter int ROWS    = 64,
  parameter int BITS    = 4,
  parameter int BASE_ON = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  output logic [$clog2(ROWS/2)+$clog2(COLS)-1:0]   fb_addr,
  input  logic [6*BITS-1:0]                        fb_data,
  output logic [2:0]                               to_screen_RGB0,
  output logic [2:0]                               to_screen_RGB1,
  output logic                                     to_screen_CLK,
  output logic [$clog2(ROWS/2)-1:0]                to_screen_ABCDE,
  output logic                                     to_screen_LATCH,
  output logic                                     to_screen_nOE,
  output logic                                     frame_done
);

  localparam int ROW_W = $clog2(ROWS/2);
  localparam int COL_W = $clog2(COLS);
  localparam int PL_W  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int ON_W  = $clog2(BASE_ON << (BITS-1)) + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS/2-1);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(BITS-1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_BLANK, S_LATCH, S_SHOW} state_t;

  state_t                   r_state;
  logic [ROW_W-1:0]         r_row;
  logic [PL_W-1:0]          r_plane;
  logic [COL_W-1:0]         r_col;
  logic                     r_phase;
  logic [ON_W-1:0]          r_on_cnt;
  logic [ROW_W+COL_W-1:0]   r_fb_addr;
  logic [2:0]               r_rgb0;
  logic [2:0]               r_rgb1;
  logic                     r_clk;
  logic [ROW_W-1:0]         r_abcde;
  logic                     r_latch;
  logic                     r_noe;
  logic                     r_frame_done;

  logic [2:0]               w_rgb0;
  logic [2:0]               w_rgb1;
  logic [ON_W-1:0]          w_dur;
  logic                     w_last_row;
  logic                     w_last_plane;
  logic [COL_W-1:0]         w_col_p1;
  logic [COL_W-1:0]         w_col_p2;

  always_comb begin
    w_rgb0 = '0;
    w_rgb1 = '0;
    for (int unsigned b = 0; b < BITS; b++) begin
      if (r_plane == PL_W'(b)) begin
        w_rgb0 = {fb_data[5*BITS+b], fb_data[4*BITS+b], fb_data[3*BITS+b]};
        w_rgb1 = {fb_data[2*BITS+b], fb_data[BITS+b],   fb_data[b]};
      end
    end
  end

  assign w_dur        = ON_W'(BASE_ON) << r_plane;
  assign w_last_row   = (r_row == ROW_LAST);
  assign w_last_plane = (r_plane == PL_LAST);
  assign w_col_p1     = r_col + COL_W'(1);
  assign w_col_p2     = r_col + COL_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_plane      <= '0;
      r_col        <= '0;
      r_phase      <= 1'b0;
      r_on_cnt     <= '0;
      r_fb_addr    <= '0;
      r_rgb0       <= '0;
      r_rgb1       <= '0;
      r_clk        <= 1'b0;
      r_abcde      <= '0;
      r_latch      <= 1'b0;
      r_noe        <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_noe   <= 1'b1;
          r_clk   <= 1'b0;
          r_latch <= 1'b0;
          if (en) begin
            r_row     <= '0;
            r_plane   <= '0;
            r_fb_addr <= '0;
            r_state   <= S_PRE;
          end
        end
        S_PRE: begin
          r_col     <= '0;
          r_phase   <= 1'b0;
          r_clk     <= 1'b0;
          r_fb_addr <= {r_row, COL_W'(1)};
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_clk   <= 1'b1;
            // Column 0's word only arrives during its own L phase (its address sat in PRE).
            if (r_col == '0) begin
              r_rgb0 <= w_rgb0;
              r_rgb1 <= w_rgb1;
            end
          end else begin
            r_phase <= 1'b0;
            r_clk   <= 1'b0;
            if (r_col == COL_LAST) begin
              r_abcde <= r_row;
              r_state <= S_BLANK;
            end else begin
              r_rgb0 <= w_rgb0;
              r_rgb1 <= w_rgb1;
              r_col  <= w_col_p1;
              if (w_col_p1 != COL_LAST) r_fb_addr <= {r_row, w_col_p2};
            end
          end
        end
        S_BLANK: begin
          r_latch <= 1'b1;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_latch      <= 1'b0;
          r_noe        <= 1'b0;
          r_on_cnt     <= w_dur - ON_W'(1);
          r_frame_done <= w_last_row && w_last_plane && (w_dur == ON_W'(1));
          r_state      <= S_SHOW;
        end
        S_SHOW: begin
          if (r_on_cnt != '0) begin
            r_on_cnt     <= r_on_cnt - ON_W'(1);
            r_frame_done <= w_last_row && w_last_plane && (r_on_cnt == ON_W'(1));
          end else begin
            r_noe <= 1'b1;
            if (!w_last_plane) begin
              r_plane   <= r_plane + PL_W'(1);
              r_fb_addr <= {r_row, COL_W'(0)};
              r_state   <= S_PRE;
            end else if (!w_last_row) begin
              r_plane   <= '0;
              r_row     <= r_row + ROW_W'(1);
              r_fb_addr <= {r_row + ROW_W'(1), COL_W'(0)};
              r_state   <= S_PRE;
            end else begin
              r_plane   <= '0;
              r_row     <= '0;
              r_fb_addr <= '0;
              r_state   <= en ? S_PRE : S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fb_addr         = r_fb_addr;
  assign to_screen_RGB0  = r_rgb0;
  assign to_screen_RGB1  = r_rgb1;
  assign to_screen_CLK   = r_clk;
  assign to_screen_ABCDE = r_abcde;
  assign to_screen_LATCH = r_latch;
  assign to_screen_nOE   = r_noe;
  assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: frame-position model checked every cycle plus literal scenario checks.
module tb_hub75_bcm_driver;

  localparam int COLS = 4, ROWS = 4, BITS = 2, BASE_ON = 2;
  localparam int ROW_W = 1, COL_W = 2, AW = ROW_W + COL_W, DW = 6*BITS;
  localparam int PLANE_BASE = 3 + 2*COLS;
  localparam int ROW_CYC = BITS*PLANE_BASE + BASE_ON*((1 << BITS) - 1);
  localparam int FRAME = (ROWS/2)*ROW_CYC;
  localparam int NREC = 2*FRAME;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data = '0;
  logic [2:0] rgb0, rgb1;
  logic sclk, latch, noe, fd;
  logic [ROW_W-1:0] abcde;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0, bad = 0;
  int model_p = 0, exp_abcde = 0;
  bit model_on = 1'b0;

  bit s_clk [NREC], s_r [NREC], s_noe [NREC], s_lat [NREC], s_fd [NREC];
  int s_ab [NREC], s_addr [NREC];

  hub75_bcm_driver #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_ON(BASE_ON)) dut (
    .clk(clk), .rst(rst), .en(en), .fb_addr(fb_addr), .fb_data(fb_data),
    .to_screen_RGB0(rgb0), .to_screen_RGB1(rgb1), .to_screen_CLK(sclk),
    .to_screen_ABCDE(abcde), .to_screen_LATCH(latch), .to_screen_nOE(noe),
    .frame_done(fd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fb_data <= mem[fb_addr];

  // Position within a frame -> row, plane, and offset k inside that plane's pass.
  function automatic void decode(input int p, output int row, output int plane, output int k);
    int len;
    bit found;
    row = p / ROW_CYC;
    k = p % ROW_CYC;
    plane = 0;
    found = 1'b0;
    for (int b = 0; b < BITS; b++) begin
      len = PLANE_BASE + (BASE_ON << b);
      if (!found) begin
        if (k < len) begin plane = b; found = 1'b1; end
        else k = k - len;
      end
    end
  endfunction

  always @(posedge clk) begin
    int r, pl, k;
    if (rst) begin
      model_on = 1'b0; model_p = 0; exp_abcde = 0;
    end else begin
      if (!model_on) begin
        if (en) begin model_on = 1'b1; model_p = 0; end
      end else if (model_p == FRAME-1) begin
        if (en) model_p = 0; else model_on = 1'b0;
      end else begin
        model_p = model_p + 1;
      end
      if (model_on) begin
        decode(model_p, r, pl, k);
        if (k == 2*COLS+1) exp_abcde = r;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int r, pl, k, col;
    logic [DW-1:0] w;
    logic [2:0] e0, e1;
    if (!model_on) begin
      chk("idle_nOE", int'(noe), 1);
      chk("idle_CLK", int'(sclk), 0);
      chk("idle_LATCH", int'(latch), 0);
      chk("idle_frame_done", int'(fd), 0);
      chk("idle_ABCDE", int'(abcde), exp_abcde);
    end else begin
      decode(model_p, r, pl, k);
      chk("CLK", int'(sclk), (k >= 1 && k <= 2*COLS && ((k-1) % 2) == 1) ? 1 : 0);
      chk("nOE", int'(noe), (k > 2*COLS+2) ? 0 : 1);
      chk("LATCH", int'(latch), (k == 2*COLS+2) ? 1 : 0);
      chk("frame_done", int'(fd), (model_p == FRAME-1) ? 1 : 0);
      chk("ABCDE", int'(abcde), exp_abcde);
      if (k <= 2*COLS) begin
        col = (k == 0) ? -1 : (k-1)/2;
        chk("fb_addr", int'(fb_addr), r*COLS + ((col+1 < COLS) ? col+1 : COLS-1));
        if (k >= 1 && ((k-1) % 2) == 1) begin
          w = mem[r*COLS + col];
          e0 = {w[5*BITS+pl], w[4*BITS+pl], w[3*BITS+pl]};
          e1 = {w[2*BITS+pl], w[BITS+pl], w[pl]};
          chk("RGB0", int'(rgb0), int'(e0));
          chk("RGB1", int'(rgb1), int'(e1));
        end
      end
    end
  endtask

  function automatic int rise_pattern(input int lo, input int hi, output int nrise);
    int v;
    v = 0;
    nrise = 0;
    for (int i = lo; i <= hi; i++) begin
      if (s_clk[i] && (i == lo || !s_clk[i-1])) begin
        v = v | (int'(s_r[i]) << nrise);
        nrise++;
      end
    end
    return v;
  endfunction

  initial begin
    int n, cnt, first, fdpos, v;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'((i % COLS) << (5*BITS));
    fork
      forever begin @(negedge clk); compare(); end
    join_none

    rst = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_RGB0", int'(rgb0), 0);
    chk("rst_RGB1", int'(rgb1), 0);
    chk("rst_CLK", int'(sclk), 0);
    chk("rst_LATCH", int'(latch), 0);
    chk("rst_nOE", int'(noe), 1);
    chk("rst_ABCDE", int'(abcde), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_frame_done", int'(fd), 0);
    rst = 1'b0;

    for (int i = 0; i < NREC; i++) begin
      @(negedge clk);
      s_clk[i] = sclk; s_r[i] = rgb0[2]; s_noe[i] = noe; s_lat[i] = latch;
      s_fd[i] = fd; s_ab[i] = int'(abcde); s_addr[i] = int'(fb_addr);
    end

    first = -1;
    for (int i = 0; i < NREC; i++) if (s_clk[i] && first < 0) first = i;
    chk("first_rise_idx", first, 2);
    chk("pre_fb_addr", s_addr[0], 0);
    chk("pre_nOE", int'(s_noe[0]), 1);

    v = rise_pattern(0, 12, n);
    chk("p0_rises", n, 4);
    chk("p0_R_bits", v, 4'b1010);
    v = rise_pattern(13, 27, n);
    chk("p1_rises", n, 4);
    chk("p1_R_bits", v, 4'b1100);

    cnt = 0; for (int i = 0; i <= 12; i++) if (!s_noe[i]) cnt++;
    chk("p0_on_cycles", cnt, 2);
    cnt = 0; for (int i = 13; i <= 27; i++) if (!s_noe[i]) cnt++;
    chk("p1_on_cycles", cnt, 4);

    chk("latch_p0", int'(s_lat[10]), 1);
    chk("latch_p1", int'(s_lat[23]), 1);
    cnt = 0; for (int i = 0; i < NREC; i++) if (s_lat[i]) cnt++;
    chk("latch_count", cnt, 8);
    cnt = 0;
    for (int i = 1; i < NREC; i++) if (s_lat[i-1] && s_noe[i]) cnt++;
    chk("latch_then_show", cnt, 0);
    cnt = 0;
    for (int i = 1; i < NREC; i++) if (!s_noe[i] && s_ab[i] != s_ab[i-1]) cnt++;
    chk("abcde_stable_on", cnt, 0);

    chk("abcde_row0", s_ab[12], 0);
    chk("abcde_row1", s_ab[40], 1);
    chk("abcde_row0_again", s_ab[70], 0);
    cnt = 0; for (int i = 0; i < NREC; i++) if (s_fd[i]) cnt++;
    chk("frame_done_count", cnt, 2);
    chk("frame_done_1", int'(s_fd[55]), 1);
    chk("frame_done_2", int'(s_fd[111]), 1);

    fdpos = -1;
    for (int j = 0; j < 120 && fdpos < 0; j++) begin
      @(negedge clk);
      if (fd) fdpos = j;
      if (j == 20) en = 1'b0;
    end
    chk("en_drop_frame_done", fdpos, 55);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (!noe || sclk || latch) cnt++; end
    chk("idle_after_drop", cnt, 0);

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h5A3 ^ (i * 713));
    en = 1'b1;
    first = -1;
    for (int j = 0; j < 20 && first < 0; j++) begin @(negedge clk); if (sclk) first = j; end
    chk("reach_phase_H", first, 2);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("midrst_CLK", int'(sclk), 0);
    chk("midrst_nOE", int'(noe), 1);
    chk("midrst_LATCH", int'(latch), 0);
    chk("midrst_fb_addr", int'(fb_addr), 0);
    chk("midrst_RGB0", int'(rgb0), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (latch || !noe || sclk) cnt++; end
    chk("no_activity_after_rst", cnt, 0);

    en = 1'b1;
    fdpos = -1;
    for (int j = 0; j < 200 && fdpos < 0; j++) begin
      @(negedge clk);
      if (fd) fdpos = j;
      if (j == 5) en = 1'b0;
    end
    chk("pattern2_frame_done", fdpos, 55);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
